// File: rtl/dxl_pkg.sv
// Dynamixel protocol 1.0 shared definitions.
// Holds the byte offsets of the 8-byte checksum window, the common
// instruction codes, the broadcast ID, and a reference checksum function
// that packet builders and scoreboards can reuse.
package dxl_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned WIN_BYTES = 8;
    localparam int unsigned WIN_W     = WIN_BYTES * BYTE_W;
    // An 8-term sum of bytes needs up to 11 bits (8 * 255 = 2040).
    localparam int unsigned SUM_W     = 11;

    // Byte offsets inside the {data2, data1} window.
    localparam int unsigned OFS_ID    = 0;
    localparam int unsigned OFS_LEN   = 1;
    localparam int unsigned OFS_INSTR = 2;
    localparam int unsigned OFS_RSVD  = 3;
    localparam int unsigned OFS_P0    = 4;
    localparam int unsigned OFS_P1    = 5;
    localparam int unsigned OFS_P2    = 6;
    localparam int unsigned OFS_P3    = 7;

    // Instruction codes.
    localparam logic [BYTE_W-1:0] INSTR_PING  = 8'h01;
    localparam logic [BYTE_W-1:0] INSTR_READ  = 8'h02;
    localparam logic [BYTE_W-1:0] INSTR_WRITE = 8'h03;

    localparam logic [BYTE_W-1:0] ID_BROADCAST = 8'hFE;

    // Inverted modulo-256 sum of all eight window bytes.
    function automatic logic [BYTE_W-1:0] dxl_checksum_f(
        input logic [WORD_W-1:0] d1,
        input logic [WORD_W-1:0] d2
    );
        logic [SUM_W-1:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s = s + SUM_W'(d1[i*BYTE_W +: BYTE_W]) + SUM_W'(d2[i*BYTE_W +: BYTE_W]);
        end
        return ~s[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/dxl_checksum.sv
// Registered Dynamixel 1.0 checksum generator.
// Sums the 8-byte packet window (data1 = bytes 0..3, data2 = bytes 4..7),
// keeps the low byte and inverts it; the result appears one clock later.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid          window on data1/data2 is to be checksummed this cycle
//   data1, data2      packet window words
//   out_valid         checksum carries a fresh result this cycle
//   checksum          ~(byte sum) mod 256, holds its value while idle
module dxl_checksum
    import dxl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] data1,
    input  logic [WORD_W-1:0] data2,
    output logic              out_valid,
    output logic [BYTE_W-1:0] checksum
);

    logic [WIN_W-1:0]  window;
    logic [BYTE_W-1:0] b_id, b_len, b_instr, b_rsvd, b_p0, b_p1, b_p2, b_p3;
    logic [SUM_W-3:0]  sum_l1_a, sum_l1_b, sum_l1_c, sum_l1_d;
    logic [SUM_W-2:0]  sum_l2_a, sum_l2_b;
    logic [SUM_W-1:0]  sum_all;

    logic              out_valid_d, out_valid_q;
    logic [BYTE_W-1:0] checksum_d,  checksum_q;

    assign window  = {data2, data1};
    assign b_id    = window[OFS_ID    * BYTE_W +: BYTE_W];
    assign b_len   = window[OFS_LEN   * BYTE_W +: BYTE_W];
    assign b_instr = window[OFS_INSTR * BYTE_W +: BYTE_W];
    assign b_rsvd  = window[OFS_RSVD  * BYTE_W +: BYTE_W];
    assign b_p0    = window[OFS_P0    * BYTE_W +: BYTE_W];
    assign b_p1    = window[OFS_P1    * BYTE_W +: BYTE_W];
    assign b_p2    = window[OFS_P2    * BYTE_W +: BYTE_W];
    assign b_p3    = window[OFS_P3    * BYTE_W +: BYTE_W];

    // Balanced adder tree, each level one bit wider than its operands.
    always_comb begin
        sum_l1_a = (SUM_W-2)'(b_id)    + (SUM_W-2)'(b_len);
        sum_l1_b = (SUM_W-2)'(b_instr) + (SUM_W-2)'(b_rsvd);
        sum_l1_c = (SUM_W-2)'(b_p0)    + (SUM_W-2)'(b_p1);
        sum_l1_d = (SUM_W-2)'(b_p2)    + (SUM_W-2)'(b_p3);
        sum_l2_a = (SUM_W-1)'(sum_l1_a) + (SUM_W-1)'(sum_l1_b);
        sum_l2_b = (SUM_W-1)'(sum_l1_c) + (SUM_W-1)'(sum_l1_d);
        sum_all  = SUM_W'(sum_l2_a) + SUM_W'(sum_l2_b);
    end

    // Capture a new result only on valid input; otherwise hold the checksum.
    always_comb begin
        out_valid_d = in_valid;
        checksum_d  = checksum_q;
        if (in_valid) begin
            checksum_d = ~sum_all[BYTE_W-1:0];
        end
    end

    // Reset wins over a coincident valid input, which is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            checksum_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            checksum_q  <= checksum_d;
        end
    end

    assign out_valid = out_valid_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_dxl_checksum.sv
// Self-checking bench for dxl_checksum: directed vectors with known
// checksums, wrap boundaries, idle hold, then random windows compared
// against an arithmetic reference model.
module tb_dxl_checksum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        out_valid;
    logic [7:0]  checksum;

    int n_total;
    int n_pass;
    logic [7:0] last_cs;

    dxl_checksum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer byte sum, wrapped and complemented.
    function automatic logic [7:0] ref_cs(input logic [31:0] d1, input logic [31:0] d2);
        int s;
        logic [63:0] w;
        w = {d2, d1};
        s = 0;
        for (int i = 0; i < 8; i++) s += int'(w[i*8 +: 8]);
        s = s % 256;
        return 8'(255 - s);
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    endtask

    // Drive one cycle at the falling edge, check registered result at the next one.
    task automatic step(input logic v, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [7:0] exp_cs, input string tag);
        in_valid = v;
        data1    = d1;
        data2    = d2;
        @(negedge clk);
        chk1({tag, "_ov"}, out_valid, v);
        chk8({tag, "_cs"}, checksum, exp_cs);
        if (v) last_cs = exp_cs;
    endtask

    initial begin
        logic [31:0] rd1, rd2;
        logic        rv;
        logic [7:0]  exp;

        n_total  = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        data1    = 32'h000305FE;
        data2    = 32'h00000006;
        last_cs  = 8'h00;

        // Reset held with a valid input present: outputs stay cleared.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk1("rst_ov", out_valid, 1'b0);
            chk8("rst_cs", checksum, 8'h00);
            @(negedge clk);
        end
        rst_n = 1'b1;
        step(1'b0, 32'h000305FE, 32'h00000006, 8'h00, "post_rst_idle");

        // Broadcast writes back-to-back.
        step(1'b1, 32'h000305FE, 32'h00000006, 8'hF3, "bcast_w0");
        step(1'b1, 32'h000305FE, 32'h00000008, 8'hF1, "bcast_w1");
        // Write stream.
        step(1'b1, 32'h00030504, 32'h0000FF20, 8'hD4, "wr_s0");
        step(1'b1, 32'h00030506, 32'h0001FF20, 8'hD1, "wr_s1");
        step(1'b1, 32'h00030508, 32'h0002FF20, 8'hCE, "wr_s2");
        // LED write and broadcast read.
        step(1'b1, 32'h00030408, 32'h00000119, 8'hD6, "led_w");
        step(1'b1, 32'h000204FE, 32'h0000012B, 8'hCF, "bcast_rd");
        // Wrap boundaries.
        step(1'b1, 32'h00000000, 32'h00000000, 8'hFF, "all_zero");
        step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h07, "all_ff");
        step(1'b1, 32'h000000FF, 32'h00000000, 8'h00, "sum_ff");
        step(1'b1, 32'h00000080, 32'h00000080, 8'hFF, "sum_100");

        // Single pulse then three idle cycles with changing data: checksum holds.
        step(1'b1, 32'h00030504, 32'h0000FF20, 8'hD4, "pulse");
        step(1'b0, 32'h12345678, 32'h9ABCDEF0, 8'hD4, "idle0");
        step(1'b0, 32'hFFFFFFFF, 32'h00000000, 8'hD4, "idle1");
        step(1'b0, 32'h00000001, 32'h00000001, 8'hD4, "idle2");

        // Random windows with random gaps, checked against the reference.
        for (int i = 0; i < 60; i++) begin
            rv  = ($urandom_range(0, 3) != 0);
            rd1 = $urandom;
            rd2 = $urandom;
            if ($urandom_range(0, 3) == 0) rd2 = rd2 & 32'h0000FFFF;
            exp = rv ? ref_cs(rd1, rd2) : last_cs;
            step(rv, rd1, rd2, exp, "rand");
        end

        // Reset mid-stream clears a pending result.
        in_valid = 1'b1;
        data1    = 32'h00000011;
        data2    = 32'h00000022;
        rst_n    = 1'b0;
        @(negedge clk);
        chk1("rst2_ov", out_valid, 1'b0);
        chk8("rst2_cs", checksum, 8'h00);
        rst_n = 1'b1;
        step(1'b1, 32'h00000011, 32'h00000022, 8'hCC, "after_rst2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
